viterbi_decoder: RTL and testbench
==================================

Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code produced by the encoder stage directly upstream.
- Consumes the encoder's serial channel bit stream, one channel bit per clock, two channel bits per data symbol.
- Recovers the original data bits using 4-state add-compare-select and register-exchange survivor paths.
- Emits one decoded bit per symbol after a fixed decision depth.

Parameters:
- TB_DEPTH, 15: survivor path length in symbols (decision depth); legal range 5..32.
- PM_W, 6: path metric width in bits; saturating arithmetic.

Ports:
- clock  input  1  single system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- in  input  1  serial channel bit from the encoder, sampled every posedge.
- out  output  1  decoded data bit; valid when out_valid=1, held otherwise.
- out_valid  output  1  one-cycle pulse marking a new decoded bit on out.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high: sampled only on posedge clock.
  - Clears phase to 0 and sym_cnt to 0.
  - Sets metric[0]=0 and metric[1..3]=2^PM_W-1.
  - Clears all survivor paths to 0.
  - Drives out=0, out_valid=0.
  - Reset asserted mid-operation aborts decoding; no further out_valid until the pipeline refills.
- Channel framing:
  - phase toggles every non-reset clock, starting at 0.
  - phase=0: in is stored as c0, the G0 bit (taps 111).
  - phase=1: in is c1, the G1 bit (taps 110); the symbol {c0,c1} completes on this edge.
  - The first bit after reset release is always c0. There is no resynchronisation.
- Trellis:
  - State index s={x0,x1}: x0 is the newest data bit and the MSB.
  - From s={a,c} with input b: next state ns={b,a}; expected bits g0=b^a^c, g1=b^a.
  - Predecessors of ns={b,a} are {a,0} and {a,1}.
- Branch metric: Hamming distance between {c0,c1} and {g0,g1}, range 0..2.
- ACS, on each symbol-complete edge:
  - cand = metric[ps] + bm, saturating at 2^PM_W-1.
  - Survivor is the smaller candidate; on a tie the predecessor with c=0 wins.
  - After ACS, subtract the minimum of the four new metrics from all four (normalisation), so the minimum is always 0.
- Survivors (register exchange): path[ns] <= {path[winner][TB_DEPTH-2:0], b}.
- Output decision:
  - best = the state with the minimum new metric; ties go to the lowest index.
  - On the symbol-complete edge: out <= new path[best][TB_DEPTH-1].
  - sym_cnt increments and saturates at TB_DEPTH.
  - out_valid <= 1 when the new sym_cnt >= TB_DEPTH, else 0.
  - out_valid is 0 on every phase=0 edge.
- Latency: data bit j (j=0 first after reset) appears with the out_valid pulse at the completion of symbol j+TB_DEPTH-1. This is 2*(j+TB_DEPTH) clocks after reset release, counting the completion edge.
- Throughput: one decoded bit per 2 clocks. out holds its value between pulses.
- Boundaries:
  - No flush mechanism; the last TB_DEPTH-1 bits are emitted only as further symbols arrive.
  - Metric saturation never wraps.

Optional Feature:
- Macro: VDEC_ERRCNT_EN.
- Defined: adds output err_count (16 bits).
  - Cleared on reset.
  - Increments, saturating at 0xFFFF, on each symbol-complete edge where the pre-normalisation minimum metric is nonzero.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 2*(TB_DEPTH+10) clocks of in=0 -> first out_valid on clock 2*TB_DEPTH; all decoded bits 0; err_count=0.
- Data 1,0,1,1 then zeros, fed through the encoder stream 11,11,01,00,... -> decoded bits 1,0,1,1,0... with bit 0 on the pulse 2*TB_DEPTH clocks after reset.
- Same stream with the c1 bit of symbol 2 flipped -> identical decoded bits; err_count increments from 0 and then stays constant, since later symbols are error-free.
- Random 200-bit data through the encoder, no errors -> decoded stream equals input delayed by TB_DEPTH symbols; out_valid pulses every 2 clocks.
- Assert reset for 1 clock mid-stream at symbol 40 -> out_valid=0 for the next 2*TB_DEPTH-1 clocks; metrics re-initialised; decoding resumes correctly.
- Noise burst of 3 consecutive flipped channel bits every 40 bits -> no saturation wrap; metrics stay below 2^PM_W-1; decoder recovers within TB_DEPTH symbols.

Source files
------------

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2 K=3 code (G0=111, G1=110), register-exchange survivors.
// Optional VDEC_ERRCNT_EN adds err_count, a saturating count of symbols whose best metric was nonzero.
module viterbi_decoder #(
   parameter int TB_DEPTH = 15,
   parameter int PM_W     = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in,
   output logic        out,
   output logic        out_valid
`ifdef VDEC_ERRCNT_EN
   ,
   output logic [15:0] err_count
`endif
);

   localparam logic [PM_W-1:0] PM_MAX = '1;
   localparam int              CNT_W  = $clog2(TB_DEPTH + 1);

   logic                phase;
   logic                c0;
   logic [PM_W-1:0]     metric [4];
   logic [TB_DEPTH-1:0] path   [4];
   logic [CNT_W-1:0]    sym_cnt;

   logic [PM_W-1:0]     cand0  [4];
   logic [PM_W-1:0]     cand1  [4];
   logic [PM_W-1:0]     acs_m  [4];
   logic [PM_W-1:0]     norm_m [4];
   logic [TB_DEPTH-1:0] acs_p  [4];
   logic [PM_W-1:0]     min_m;
   logic [1:0]          best;
   logic [1:0]          ns;
   logic [CNT_W-1:0]    cnt_nxt;

   function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] m, input logic [1:0] d);
      logic [PM_W:0] s;
      s = {1'b0, m} + {{(PM_W-1){1'b0}}, d};
      return (s > {1'b0, PM_MAX}) ? PM_MAX : s[PM_W-1:0];
   endfunction

   // ps = {a,c}; expected bits for input b are g0=b^a^c, g1=b^a
   function automatic logic [1:0] branch_metric(input logic [1:0] ps, input logic b,
                                                 input logic r0, input logic r1);
      logic g0, g1;
      g0 = b ^ ps[1] ^ ps[0];
      g1 = b ^ ps[1];
      return {1'b0, g0 ^ r0} + {1'b0, g1 ^ r1};
   endfunction

   always_comb begin
      cand0  = '{default: '0};
      cand1  = '{default: '0};
      acs_m  = '{default: '0};
      acs_p  = '{default: '0};
      norm_m = '{default: '0};
      ns     = '0;
      for (int i = 0; i < 4; i++) begin
         ns       = 2'(i);
         cand0[i] = sat_add(metric[{ns[0], 1'b0}], branch_metric({ns[0], 1'b0}, ns[1], c0, in));
         cand1[i] = sat_add(metric[{ns[0], 1'b1}], branch_metric({ns[0], 1'b1}, ns[1], c0, in));
         // ties resolve toward the predecessor whose oldest bit is 0
         if (cand1[i] < cand0[i]) begin
            acs_m[i] = cand1[i];
            acs_p[i] = {path[{ns[0], 1'b1}][TB_DEPTH-2:0], ns[1]};
         end else begin
            acs_m[i] = cand0[i];
            acs_p[i] = {path[{ns[0], 1'b0}][TB_DEPTH-2:0], ns[1]};
         end
      end
      min_m = acs_m[0];
      best  = '0;
      for (int i = 1; i < 4; i++) begin
         if (acs_m[i] < min_m) begin
            min_m = acs_m[i];
            best  = 2'(i);
         end
      end
      for (int i = 0; i < 4; i++) norm_m[i] = acs_m[i] - min_m;
      cnt_nxt = (sym_cnt == CNT_W'(TB_DEPTH)) ? sym_cnt : sym_cnt + CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase     <= 1'b0;
         c0        <= 1'b0;
         sym_cnt   <= '0;
         out       <= 1'b0;
         out_valid <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            metric[i] <= (i == 0) ? '0 : PM_MAX;
            path[i]   <= '0;
         end
`ifdef VDEC_ERRCNT_EN
         err_count <= '0;
`endif
      end else begin
         phase <= ~phase;
         if (!phase) begin
            c0        <= in;
            out_valid <= 1'b0;
         end else begin
            for (int i = 0; i < 4; i++) begin
               metric[i] <= norm_m[i];
               path[i]   <= acs_p[i];
            end
            sym_cnt   <= cnt_nxt;
            out       <= acs_p[best][TB_DEPTH-1];
            out_valid <= (cnt_nxt >= CNT_W'(TB_DEPTH));
`ifdef VDEC_ERRCNT_EN
            if (min_m != '0 && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: a reference encoder feeds the DUT and queues the data bits it expects back.
// Checks err_count as well when built with VDEC_ERRCNT_EN.
module tb_viterbi_decoder;
   localparam int TB_DEPTH = 15;
   localparam int PM_W     = 6;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic in    = 1'b0;
   logic out, out_valid;
`ifdef VDEC_ERRCNT_EN
   logic [15:0] err_count;
`endif

   always #5 clock = ~clock;

   viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
      .clock(clock), .reset(reset), .in(in), .out(out), .out_valid(out_valid)
`ifdef VDEC_ERRCNT_EN
      , .err_count(err_count)
`endif
   );

   int         n_cmp = 0;
   int         n_err = 0;
   int         clk_cnt, sym_cnt;
   logic       e0, e1;
   logic [1:0] exp_q[$];
   logic       obs_v0, obs_v1, obs_out0, obs_out;

   task automatic tick(input logic b);
      in = b;
      @(posedge clock);
      #1;
      clk_cnt++;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      in    = 1'b0;
      repeat (cycles) begin
         @(posedge clock);
         #1;
      end
      reset   = 1'b0;
      clk_cnt = 0;
      sym_cnt = 0;
      e0      = 1'b0;
      e1      = 1'b0;
      exp_q.delete();
   endtask

   // encodes one data bit, optionally corrupts its channel bits, queues {check, bit}
   task automatic drive_sym(input logic b, input logic f0, input logic f1, input logic chk);
      logic g0, g1;
      g0 = b ^ e0 ^ e1;
      g1 = b ^ e0;
      e1 = e0;
      e0 = b;
      exp_q.push_back({chk, b});
      sym_cnt++;
      tick(g0 ^ f0);
      obs_v0   = out_valid;
      obs_out0 = out;
      tick(g1 ^ f1);
      obs_v1   = out_valid;
      obs_out  = out;
   endtask

   task automatic test_reset();
      in = 1'b1;
      do_reset(3);
      n_cmp++;
      if (out !== 1'b0) begin n_err++; $display("FAIL reset_out: got %b want 0", out); end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
`ifdef VDEC_ERRCNT_EN
      n_cmp++;
      if (err_count !== 16'd0) begin n_err++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
`endif
   endtask

   task automatic test_zeros();
      int first;
      logic [1:0] e;
      first = -1;
      do_reset(2);
      for (int s = 0; s < TB_DEPTH + 10; s++) begin
         drive_sym(1'b0, 1'b0, 1'b0, 1'b1);
         n_cmp++;
         if (obs_v0 !== 1'b0) begin n_err++; $display("FAIL zeros_v0 sym %0d: got %b want 0", s, obs_v0); end
         n_cmp++;
         if (obs_v1 !== (sym_cnt >= TB_DEPTH)) begin n_err++; $display("FAIL zeros_v1 sym %0d: got %b want %b", s, obs_v1, sym_cnt >= TB_DEPTH); end
         if (obs_v1 === 1'b1 && exp_q.size() > 0) begin
            if (first < 0) first = clk_cnt;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_out !== e[0]) begin n_err++; $display("FAIL zeros_bit sym %0d: got %b want %b", s, obs_out, e[0]); end
         end
      end
      n_cmp++;
      if (first != 2 * TB_DEPTH) begin n_err++; $display("FAIL zeros_latency: got clock %0d want %0d", first, 2 * TB_DEPTH); end
      n_cmp++;
      if (exp_q.size() != TB_DEPTH - 1) begin n_err++; $display("FAIL zeros_pending: got %0d want %0d", exp_q.size(), TB_DEPTH - 1); end
`ifdef VDEC_ERRCNT_EN
      n_cmp++;
      if (err_count !== 16'd0) begin n_err++; $display("FAIL zeros_errcnt: got %0d want 0", err_count); end
`endif
   endtask

   // data 1,0,1,1 then zeros; with flip set, c1 of symbol 2 is corrupted
   task automatic test_pattern(input logic flip);
      logic [3:0] pat;
      logic [1:0] e;
      logic       b;
      int         first;
      logic [15:0] err_early, err_mid;
      pat = 4'b1101;
      first = -1;
      err_early = '0;
      err_mid = '0;
      do_reset(1);
      for (int s = 0; s < TB_DEPTH + 12; s++) begin
         b = (s < 4) ? pat[s] : 1'b0;
         drive_sym(b, 1'b0, flip && (s == 2), 1'b1);
`ifdef VDEC_ERRCNT_EN
         if (s == 1) err_early = err_count;
         if (s == TB_DEPTH - 1) err_mid = err_count;
`endif
         n_cmp++;
         if (obs_v1 !== (sym_cnt >= TB_DEPTH)) begin n_err++; $display("FAIL pattern_v1 flip %b sym %0d: got %b", flip, s, obs_v1); end
         if (obs_v1 === 1'b1 && exp_q.size() > 0) begin
            if (first < 0) first = clk_cnt;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_out !== e[0]) begin n_err++; $display("FAIL pattern_bit flip %b sym %0d: got %b want %b", flip, s, obs_out, e[0]); end
         end
      end
      n_cmp++;
      if (first != 2 * TB_DEPTH) begin n_err++; $display("FAIL pattern_latency flip %b: got clock %0d want %0d", flip, first, 2 * TB_DEPTH); end
`ifdef VDEC_ERRCNT_EN
      n_cmp++;
      if (err_early !== 16'd0) begin n_err++; $display("FAIL pattern_errcnt_early: got %0d want 0", err_early); end
      n_cmp++;
      if (err_count !== err_mid) begin n_err++; $display("FAIL pattern_errcnt_stable: got %0d want %0d", err_count, err_mid); end
      n_cmp++;
      if ((err_count != 16'd0) !== flip) begin n_err++; $display("FAIL pattern_errcnt_nonzero: got %0d flip %b", err_count, flip); end
`endif
   endtask

   task automatic test_random();
      logic [1:0] e;
      logic       prev_out;
      do_reset(1);
      prev_out = 1'b0;
      for (int s = 0; s < 200; s++) begin
         drive_sym(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
         n_cmp++;
         if (obs_v0 !== 1'b0) begin n_err++; $display("FAIL random_v0 sym %0d: got %b want 0", s, obs_v0); end
         n_cmp++;
         if (obs_out0 !== prev_out) begin n_err++; $display("FAIL random_hold sym %0d: got %b want %b", s, obs_out0, prev_out); end
         n_cmp++;
         if (obs_v1 !== (sym_cnt >= TB_DEPTH)) begin n_err++; $display("FAIL random_v1 sym %0d: got %b", s, obs_v1); end
         if (obs_v1 === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_out !== e[0]) begin n_err++; $display("FAIL random_bit sym %0d: got %b want %b", s, obs_out, e[0]); end
         end
         prev_out = obs_out;
      end
      n_cmp++;
      if (exp_q.size() != TB_DEPTH - 1) begin n_err++; $display("FAIL random_pending: got %0d want %0d", exp_q.size(), TB_DEPTH - 1); end
   endtask

   task automatic test_mid_reset();
      logic [1:0] e;
      int first;
      first = -1;
      do_reset(1);
      for (int s = 0; s < 40; s++) drive_sym(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
      do_reset(1);
      n_cmp++;
      if (out_valid !== 1'b0 || out !== 1'b0) begin n_err++; $display("FAIL midreset_clear: got out %b valid %b want 0 0", out, out_valid); end
      for (int s = 0; s < 40; s++) begin
         drive_sym(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
         n_cmp++;
         if (obs_v0 !== 1'b0) begin n_err++; $display("FAIL midreset_v0 sym %0d: got %b want 0", s, obs_v0); end
         n_cmp++;
         if (obs_v1 !== (sym_cnt >= TB_DEPTH)) begin n_err++; $display("FAIL midreset_v1 sym %0d: got %b", s, obs_v1); end
         if (obs_v1 === 1'b1 && exp_q.size() > 0) begin
            if (first < 0) first = clk_cnt;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_out !== e[0]) begin n_err++; $display("FAIL midreset_bit sym %0d: got %b want %b", s, obs_out, e[0]); end
         end
      end
      n_cmp++;
      if (first != 2 * TB_DEPTH) begin n_err++; $display("FAIL midreset_latency: got clock %0d want %0d", first, 2 * TB_DEPTH); end
   endtask

   // 3-bit bursts every 20 symbols; only bits well clear of a burst are scored
   task automatic test_burst();
      logic [1:0] e;
      logic       f0, f1, chk, burst;
      int         m, scored;
      scored = 0;
      do_reset(1);
      for (int s = 0; s < 130; s++) begin
         m     = s % 20;
         burst = (s >= 20 && s < 100);
         f0    = burst && (m == 0 || m == 1);
         f1    = burst && (m == 0);
         chk   = (m >= 8 && m <= 14) || (s >= 95);
         drive_sym(1'($urandom_range(0, 1)), f0, f1, chk);
         n_cmp++;
         if (obs_v1 !== (sym_cnt >= TB_DEPTH)) begin n_err++; $display("FAIL burst_v1 sym %0d: got %b", s, obs_v1); end
         if (obs_v1 === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[1]) begin
               scored++;
               n_cmp++;
               if (obs_out !== e[0]) begin n_err++; $display("FAIL burst_bit sym %0d: got %b want %b", s, obs_out, e[0]); end
            end
         end
      end
      n_cmp++;
      if (scored < 50) begin n_err++; $display("FAIL burst_scored: got %0d want at least 50", scored); end
`ifdef VDEC_ERRCNT_EN
      n_cmp++;
      if (err_count == 16'd0 || err_count == 16'hFFFF) begin n_err++; $display("FAIL burst_errcnt: got %0d want nonzero unsaturated", err_count); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_zeros();
      test_pattern(1'b0);
      test_pattern(1'b1);
      test_random();
      test_mid_reset();
      test_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
